i2c_cmd_seq: RTL and testbench
==============================

Name: i2c_cmd_seq

Overview:
- Command sequencer directly upstream of the I2C master; sole driver of the master's local-bus (LB) port.
- Accepts 16-bit register-write commands (e.g. audio-codec {reg[6:0], data[8:0]} words) into a small FIFO.
- For each command: loads the master's data cache, fires a START+STOP 2-byte write, polls status until idle, and flags NACKs.
- Programs the master's device-address and clock-divider registers once after reset.

Parameters:
LB_DATA_W, 32, LB data width
LB_ADDR_W, 8, LB address width
CMD_FIFO_DEPTH, 8, command FIFO entries; power of 2, >=2
I2C_DEV_ADDR, 7'h1A, 7-bit slave address written to master
I2C_CLK_DIV, 8'd250, value written to master clock-divider register
POLL_GAP, 4, idle cycles before each status read (min 2)
ADDR_REG_ADDR, 8'h00, master address register
CLK_DIV_REG_ADDR, 8'h01, master clock-divider register
CONFIG_REG_ADDR, 8'h02, master config register
STATUS_REG_ADDR, 8'h03, master status register (bit0 busy, bit1 nack_det)
DATA_CACHE_BASE_ADDR, 8'h10, master data-cache byte 0
TIMEOUT_POLLS, 1024, max status polls per command (optional feature only)

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
cmd_valid  in  1  command present
cmd_data  in  16  command word; byte0 = [15:8], byte1 = [7:0]
cmd_ready  out  1  FIFO not full
mst_lb_wr_en  out  1  LB write strobe to master
mst_lb_rd_en  out  1  LB read strobe to master
mst_lb_addr  out  LB_ADDR_W  LB address
mst_lb_wr_data  out  LB_DATA_W  LB write data
mst_lb_wr_valid  in  1  master write acknowledge
mst_lb_rd_valid  in  1  master read-data valid
mst_lb_rd_data  in  LB_DATA_W  master read data
seq_busy  out  1  init or command in progress, or FIFO non-empty
nack_err  out  1  sticky; set on any NACK; cleared only by reset
cmd_done_cnt  out  16  commands completed; wraps 0xFFFF->0

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - All outputs 0, except cmd_ready = 0 during reset and 1 from the first cycle after reset release.
  - FIFO empty; FSM in INIT_ADDR.
- Reset mid-transaction: everything aborts immediately; FIFO contents lost. The master is reset by the same rst_n.
- FIFO:
  - Push on cmd_valid & cmd_ready. cmd_ready = ~full.
  - Pop only in IDLE when non-empty; pop and push in the same cycle are both honoured.
  - Pointers wrap modulo CMD_FIFO_DEPTH; occupancy counter is log2(DEPTH)+1 bits.
- LB write rule:
  - mst_lb_wr_en high for exactly 1 cycle with addr/data.
  - addr/data held stable until mst_lb_wr_valid; the FSM advances the cycle after wr_valid.
  - At most one LB transaction outstanding. wr_en and rd_en are never high together.
- LB read rule:
  - mst_lb_rd_en high for 1 cycle; response captured on mst_lb_rd_valid.
- FSM states:
  - INIT_ADDR: write ADDR_REG_ADDR = {I2C_DEV_ADDR,1'b0} zero-extended -> INIT_DIV.
  - INIT_DIV: write CLK_DIV_REG_ADDR = I2C_CLK_DIV -> IDLE.
  - IDLE: if FIFO non-empty, pop into cmd_reg -> WR_D0.
  - WR_D0: write DATA_CACHE_BASE_ADDR = cmd_reg[15:8] -> WR_D1.
  - WR_D1: write DATA_CACHE_BASE_ADDR+1 = cmd_reg[7:0] -> WR_CFG.
  - WR_CFG: write CONFIG_REG_ADDR = 32'h0000_0207 (num_bytes=2 at [8+], rd_n_wr=0, init=1, stop=1, start=1) -> GAP.
  - GAP: count POLL_GAP cycles (covers master init latency) -> POLL_RD.
  - POLL_RD: issue status read; on rd_valid:
    - if busy bit0 = 1 -> GAP;
    - else set nack_err if bit1 = 1, increment cmd_done_cnt -> IDLE.
- seq_busy = (state != IDLE) | FIFO non-empty.
- A command whose byte values are 0x00 is sent normally; no special cases.

Optional Feature:
- Macro: I2C_CMD_SEQ_TIMEOUT_EN.
- Defined:
  - A poll counter is cleared on entry to WR_CFG.
  - If TIMEOUT_POLLS reads all return busy: set sticky output timeout_err (extra 1-bit port, reset 0), do not increment cmd_done_cnt, return to IDLE, continue with the next command.
- Undefined: no port, no counter; polling is unbounded.

Test Plan:
- Reset release, master stub acks in 1 cycle:
  - writes in order: addr 0x00 data 0x34, then 0x01 data 0xFA;
  - seq_busy falls after INIT_DIV; cmd_ready = 1.
- Push cmd 0x1E00, stub status busy for 3 polls then 0x0:
  - writes 0x10=0x1E, 0x11=0x00, 0x02=0x207;
  - exactly 4 status reads, each preceded by >=4 idle cycles;
  - cmd_done_cnt = 1; nack_err = 0.
- Push 8 commands back-to-back with the sequencer stalled in polling:
  - cmd_ready drops after the 8th;
  - a 9th cmd_valid is held off and accepted after the first pop;
  - all 9 are issued in order.
- Stub returns status 0x2 on the final poll of command 2 of 3:
  - nack_err sets and stays 1;
  - command 3 still issued; cmd_done_cnt = 3.
- Assert rst_n low mid WR_D1:
  - all outputs 0 asynchronously;
  - after release the sequence restarts at INIT_ADDR with an empty FIFO.
- With I2C_CMD_SEQ_TIMEOUT_EN and TIMEOUT_POLLS = 4, stub permanently busy:
  - exactly 4 reads, timeout_err = 1, cmd_done_cnt unchanged, FSM back to IDLE.

Source files
------------

// File: rtl/i2c_cmd_seq.sv
// rtl/i2c_cmd_seq.sv - command FIFO and LB sequencer driving an I2C master
// Optional poll timeout: define I2C_CMD_SEQ_TIMEOUT_EN.
module i2c_cmd_seq #(
  parameter int                   LB_DATA_W            = 32,
  parameter int                   LB_ADDR_W            = 8,
  parameter int                   CMD_FIFO_DEPTH       = 8,
  parameter logic [6:0]           I2C_DEV_ADDR         = 7'h1A,
  parameter logic [7:0]           I2C_CLK_DIV          = 8'd250,
  parameter int                   POLL_GAP             = 4,
  parameter logic [LB_ADDR_W-1:0] ADDR_REG_ADDR        = 8'h00,
  parameter logic [LB_ADDR_W-1:0] CLK_DIV_REG_ADDR     = 8'h01,
  parameter logic [LB_ADDR_W-1:0] CONFIG_REG_ADDR      = 8'h02,
  parameter logic [LB_ADDR_W-1:0] STATUS_REG_ADDR      = 8'h03,
  parameter logic [LB_ADDR_W-1:0] DATA_CACHE_BASE_ADDR = 8'h10
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
  , parameter int                 TIMEOUT_POLLS        = 1024
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  input  logic [15:0]          cmd_data,
  output logic                 cmd_ready,
  output logic                 mst_lb_wr_en,
  output logic                 mst_lb_rd_en,
  output logic [LB_ADDR_W-1:0] mst_lb_addr,
  output logic [LB_DATA_W-1:0] mst_lb_wr_data,
  input  logic                 mst_lb_wr_valid,
  input  logic                 mst_lb_rd_valid,
  input  logic [LB_DATA_W-1:0] mst_lb_rd_data,
  output logic                 seq_busy,
  output logic                 nack_err,
  output logic [15:0]          cmd_done_cnt
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
  , output logic               timeout_err
`endif
);

  localparam int PTR_W = $clog2(CMD_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = $clog2(POLL_GAP) + 1;

  typedef enum logic [2:0] {
    INIT_ADDR, INIT_DIV, IDLE, WR_D0, WR_D1, WR_CFG, GAP, POLL_RD
  } state_t;

  state_t                 state_q, state_d, wnext;
  logic                   pend_q, pend_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [15:0]            cmd_reg_q, cmd_reg_d;
  logic [15:0]            fifo_q [CMD_FIFO_DEPTH];
  logic [15:0]            fifo_d [CMD_FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [LB_ADDR_W-1:0]   addr_q, addr_d, wa;
  logic [LB_DATA_W-1:0]   wdata_q, wdata_d, wd;
  logic                   busy_q, busy_d, nack_q, nack_d;
  logic [15:0]            done_q, done_d;
  logic                   push, pop, is_wr;
  logic                   unused_rd_bits;
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
  localparam int POLL_W = $clog2(TIMEOUT_POLLS) + 1;
  logic [POLL_W-1:0]      poll_q, poll_d;
  logic                   tmo_q, tmo_d;
  assign timeout_err = tmo_q;
`endif

  assign unused_rd_bits = ^mst_lb_rd_data[LB_DATA_W-1:2];
  assign cmd_ready      = cmd_ready_q;
  assign mst_lb_wr_en   = wr_en_q;
  assign mst_lb_rd_en   = rd_en_q;
  assign mst_lb_addr    = addr_q;
  assign mst_lb_wr_data = wdata_q;
  assign seq_busy       = busy_q;
  assign nack_err       = nack_q;
  assign cmd_done_cnt   = done_q;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    gap_d     = '0;
    cmd_reg_d = cmd_reg_q;
    fifo_d    = fifo_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    nack_d    = nack_q;
    done_d    = done_q;
    push      = cmd_valid & cmd_ready_q;
    pop       = 1'b0;
    is_wr     = 1'b1;
    wa        = '0;
    wd        = '0;
    wnext     = state_q;
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
    poll_d    = poll_q;
    tmo_d     = tmo_q;
`endif

    // All write states share one strobe/hold/ack handshake.
    case (state_q)
      INIT_ADDR: begin wa = ADDR_REG_ADDR; wd = LB_DATA_W'({I2C_DEV_ADDR, 1'b0}); wnext = INIT_DIV; end
      INIT_DIV:  begin wa = CLK_DIV_REG_ADDR; wd = LB_DATA_W'(I2C_CLK_DIV); wnext = IDLE; end
      WR_D0:     begin wa = DATA_CACHE_BASE_ADDR; wd = LB_DATA_W'(cmd_reg_q[15:8]); wnext = WR_D1; end
      WR_D1:     begin wa = DATA_CACHE_BASE_ADDR + LB_ADDR_W'(1); wd = LB_DATA_W'(cmd_reg_q[7:0]); wnext = WR_CFG; end
      WR_CFG:    begin wa = CONFIG_REG_ADDR; wd = LB_DATA_W'(32'h0000_0207); wnext = GAP; end
      default:   is_wr = 1'b0;
    endcase

    if (is_wr) begin
      if (!pend_q) begin
        wr_en_d = 1'b1;
        addr_d  = wa;
        wdata_d = wd;
        pend_d  = 1'b1;
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
        if (state_q == WR_CFG) poll_d = '0;
`endif
      end else if (mst_lb_wr_valid) begin
        pend_d  = 1'b0;
        state_d = wnext;
      end
    end

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          cmd_reg_d = fifo_q[rd_ptr_q];
          state_d   = WR_D0;
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(POLL_GAP - 1)) state_d = POLL_RD;
        else gap_d = gap_q + GAP_W'(1);
      end
      POLL_RD: begin
        if (!pend_q) begin
          rd_en_d = 1'b1;
          addr_d  = STATUS_REG_ADDR;
          pend_d  = 1'b1;
        end else if (mst_lb_rd_valid) begin
          pend_d = 1'b0;
          if (mst_lb_rd_data[0]) begin
            state_d = GAP;
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
            poll_d = poll_q + POLL_W'(1);
            if (poll_q == POLL_W'(TIMEOUT_POLLS - 1)) begin
              tmo_d   = 1'b1;
              state_d = IDLE;
            end
`endif
          end else begin
            nack_d  = nack_q | mst_lb_rd_data[1];
            done_d  = done_q + 16'd1;
            state_d = IDLE;
          end
        end
      end
      default: ;
    endcase

    if (push) fifo_d[wr_ptr_q] = cmd_data;
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    cmd_ready_d = (count_d != CNT_W'(CMD_FIFO_DEPTH));
    busy_d      = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT_ADDR;
      pend_q      <= 1'b0;
      gap_q       <= '0;
      cmd_reg_q   <= '0;
      for (int i = 0; i < CMD_FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      nack_q      <= 1'b0;
      done_q      <= '0;
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
      poll_q      <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      gap_q       <= gap_d;
      cmd_reg_q   <= cmd_reg_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      nack_q      <= nack_d;
      done_q      <= done_d;
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
      poll_q      <= poll_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// tb/tb_i2c_cmd_seq.sv - randomized bench with I2C master stub and command-level model
module tb_i2c_cmd_seq;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int BUDGET = 5000;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [15:0]   cmd_data = '0;
  logic          cmd_ready;
  logic          mst_lb_wr_en, mst_lb_rd_en;
  logic [AW-1:0] mst_lb_addr;
  logic [DW-1:0] mst_lb_wr_data;
  logic          mst_lb_wr_valid = 1'b0, mst_lb_rd_valid = 1'b0;
  logic [DW-1:0] mst_lb_rd_data = '0;
  logic          seq_busy, nack_err;
  logic [15:0]   cmd_done_cnt;
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
  logic          timeout_err;
`endif

  always #5 clk = ~clk;

  i2c_cmd_seq #(
    .POLL_GAP(4)
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
    , .TIMEOUT_POLLS(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .mst_lb_wr_en(mst_lb_wr_en), .mst_lb_rd_en(mst_lb_rd_en), .mst_lb_addr(mst_lb_addr),
    .mst_lb_wr_data(mst_lb_wr_data), .mst_lb_wr_valid(mst_lb_wr_valid),
    .mst_lb_rd_valid(mst_lb_rd_valid), .mst_lb_rd_data(mst_lb_rd_data),
    .seq_busy(seq_busy), .nack_err(nack_err), .cmd_done_cnt(cmd_done_cnt)
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  int checks = 0, errors = 0;

  // Stub state: one outstanding transaction, status scripted per command index.
  int          cyc = 0, last_resp_cyc = 0, min_idle = 1000, proto_err = 0;
  int          cmd_idx = 0, delay = 0, sidx = 0;
  bit          pend = 0, pend_is_wr = 0;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;
  logic [39:0] wr_log[$];
  int          rd_cnt[256];
  int          busy_tbl[256];
  bit          nack_tbl[256];
  bit          rand_delay = 0;

  always @(negedge clk) begin
    cyc++;
    mst_lb_wr_valid = 1'b0;
    mst_lb_rd_valid = 1'b0;
    mst_lb_rd_data  = '0;
    if (!rst_n) begin
      pend = 0;
      wr_log.delete();
      min_idle = 1000;
    end else begin
      if (mst_lb_wr_en && mst_lb_rd_en) proto_err++;
      if (mst_lb_wr_en || mst_lb_rd_en) begin
        if (pend) proto_err++;
        pend = 1; pend_is_wr = mst_lb_wr_en;
        p_addr = mst_lb_addr; p_data = mst_lb_wr_data;
        delay = rand_delay ? int'($urandom_range(0, 2)) : 0;
        if (mst_lb_wr_en) begin
          wr_log.push_back({mst_lb_addr, mst_lb_wr_data});
          if (mst_lb_addr == 8'h02) cmd_idx++;
        end else begin
          if (cyc - last_resp_cyc - 1 < min_idle) min_idle = cyc - last_resp_cyc - 1;
          if (cmd_idx > 0) rd_cnt[cmd_idx-1]++;
        end
      end else if (pend && pend_is_wr && (mst_lb_addr !== p_addr || mst_lb_wr_data !== p_data)) begin
        proto_err++;
      end
      if (pend) begin
        if (delay == 0) begin
          pend = 0;
          last_resp_cyc = cyc;
          if (pend_is_wr) mst_lb_wr_valid = 1'b1;
          else begin
            sidx = (cmd_idx > 0) ? cmd_idx - 1 : 0;
            mst_lb_rd_valid = 1'b1;
            mst_lb_rd_data  = (rd_cnt[sidx] <= busy_tbl[sidx]) ? 32'h1 : (nack_tbl[sidx] ? 32'h2 : 32'h0);
          end
        end else delay--;
      end
    end
  end

  // Command-level reference model.
  logic [39:0] exp_wr[$];
  int          nxt = 0;
  int          exp_done = 0;
  bit          exp_nack = 0;

  function automatic void model_init();
    exp_wr.delete();
    exp_wr.push_back({8'h00, 32'h34});
    exp_wr.push_back({8'h01, 32'hFA});
    exp_done = 0;
    exp_nack = 0;
  endfunction

  function automatic void model_cmd(input logic [15:0] c);
    exp_wr.push_back({8'h10, 24'h0, c[15:8]});
    exp_wr.push_back({8'h11, 24'h0, c[7:0]});
    exp_wr.push_back({8'h02, 32'h207});
  endfunction

  function automatic int first_wr_diff();
    if (wr_log.size() != exp_wr.size()) return -2;
    foreach (exp_wr[i]) if (wr_log[i] !== exp_wr[i]) return i;
    return -1;
  endfunction

  task automatic push_cmd(input logic [15:0] d, output int held);
    held = 0;
    cmd_valid = 1'b1;
    cmd_data  = d;
    while (!cmd_ready && held < BUDGET) begin @(negedge clk); held++; end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (seq_busy && n < BUDGET) begin @(negedge clk); n++; end
    ok = (n < BUDGET);
  endtask

  task automatic test_reset;
    bit ok;
    int d;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, mst_lb_wr_en, mst_lb_rd_en, mst_lb_addr, mst_lb_wr_data, seq_busy, nack_err, cmd_done_cnt} !== '0) begin
      errors++; $display("FAIL reset_outputs: got rdy=%b wr=%b rd=%b busy=%b done=%0d, required all 0", cmd_ready, mst_lb_wr_en, mst_lb_rd_en, seq_busy, cmd_done_cnt);
    end
    model_init();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL init_timeout: seq_busy stuck, required 0"); end
    d = first_wr_diff();
    checks++;
    if (d != -1) begin errors++; $display("FAIL init_writes: diff at %0d (got %0d writes, required %0d)", d, wr_log.size(), exp_wr.size()); end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL init_cmd_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_single;
    bit ok;
    int held, d;
    int idx = nxt;
    busy_tbl[idx] = 3; nack_tbl[idx] = 0;
    push_cmd(16'h1E00, held);
    model_cmd(16'h1E00); nxt++; exp_done++;
    wait_idle(ok);
    d = first_wr_diff();
    checks++;
    if (!ok || d != -1) begin errors++; $display("FAIL single_writes: ok=%b diff=%0d, required ok=1 diff=-1", ok, d); end
    checks++;
    if (rd_cnt[idx] != 4) begin errors++; $display("FAIL single_reads: got %0d required 4", rd_cnt[idx]); end
    checks++;
    if (min_idle < 4) begin errors++; $display("FAIL poll_gap: got %0d idle cycles, required >= 4", min_idle); end
    checks++;
    if (cmd_done_cnt !== 16'(exp_done) || nack_err !== 1'b0) begin
      errors++; $display("FAIL single_status: done=%0d nack=%b, required done=%0d nack=0", cmd_done_cnt, nack_err, exp_done);
    end
  endtask

  task automatic test_random;
    bit ok;
    int held, d;
    int base = nxt;
    logic [15:0] c;
    rand_delay = 1;
    for (int k = 0; k < 6; k++) begin
      c = 16'($urandom);
      busy_tbl[nxt] = $urandom_range(0, 3); nack_tbl[nxt] = 0;
      push_cmd(c, held);
      model_cmd(c); nxt++; exp_done++;
    end
    wait_idle(ok);
    rand_delay = 0;
    d = first_wr_diff();
    checks++;
    if (!ok || d != -1) begin errors++; $display("FAIL random_writes: ok=%b diff=%0d, required ok=1 diff=-1", ok, d); end
    for (int k = base; k < nxt; k++) begin
      checks++;
      if (rd_cnt[k] != busy_tbl[k] + 1) begin errors++; $display("FAIL random_reads[%0d]: got %0d required %0d", k, rd_cnt[k], busy_tbl[k] + 1); end
    end
    checks++;
    if (cmd_done_cnt !== 16'(exp_done) || proto_err != 0) begin
      errors++; $display("FAIL random_status: done=%0d proto=%0d, required done=%0d proto=0", cmd_done_cnt, proto_err, exp_done);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int held, d, n;
    int stall = nxt;
    logic [15:0] c;
    busy_tbl[stall] = 30; nack_tbl[stall] = 0;
    push_cmd(16'hA5C3, held);
    model_cmd(16'hA5C3); nxt++; exp_done++;
    n = 0;
    while (rd_cnt[stall] < 1 && n < BUDGET) begin @(negedge clk); n++; end
    for (int k = 0; k < 8; k++) begin
      c = 16'($urandom);
      busy_tbl[nxt] = 0; nack_tbl[nxt] = 0;
      push_cmd(c, held);
      model_cmd(c); nxt++; exp_done++;
    end
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b required 0", cmd_ready); end
    c = 16'($urandom);
    busy_tbl[nxt] = 0; nack_tbl[nxt] = 0;
    push_cmd(c, held);
    model_cmd(c); nxt++; exp_done++;
    checks++;
    if (held == 0 || held >= BUDGET || rd_cnt[stall] != 31) begin
      errors++; $display("FAIL ninth_held: held=%0d stall_reads=%0d, required held>0 and stall_reads=31", held, rd_cnt[stall]);
    end
    wait_idle(ok);
    d = first_wr_diff();
    checks++;
    if (!ok || d != -1) begin errors++; $display("FAIL b2b_order: ok=%b diff=%0d, required ok=1 diff=-1", ok, d); end
    checks++;
    if (cmd_done_cnt !== 16'(exp_done)) begin errors++; $display("FAIL b2b_done: got %0d required %0d", cmd_done_cnt, exp_done); end
  endtask

  task automatic test_nack;
    bit ok;
    int held, d;
    logic [15:0] c;
    for (int k = 0; k < 3; k++) begin
      c = 16'($urandom);
      busy_tbl[nxt] = $urandom_range(0, 2); nack_tbl[nxt] = (k == 1);
      exp_nack = exp_nack | (k == 1);
      push_cmd(c, held);
      model_cmd(c); nxt++; exp_done++;
    end
    wait_idle(ok);
    d = first_wr_diff();
    checks++;
    if (!ok || d != -1) begin errors++; $display("FAIL nack_writes: ok=%b diff=%0d, required ok=1 diff=-1", ok, d); end
    repeat (5) @(negedge clk);
    checks++;
    if (nack_err !== exp_nack) begin errors++; $display("FAIL nack_sticky: got %b required %b", nack_err, exp_nack); end
    checks++;
    if (cmd_done_cnt !== 16'(exp_done)) begin errors++; $display("FAIL nack_done: got %0d required %0d", cmd_done_cnt, exp_done); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int held, n;
    busy_tbl[nxt] = 0; nack_tbl[nxt] = 0;
    push_cmd(16'h1234, held);
    push_cmd(16'h5678, held);
    push_cmd(16'h9ABC, held);
    n = 0;
    while (!(mst_lb_wr_en && mst_lb_addr == 8'h11) && n < BUDGET) begin @(negedge clk); n++; end
    checks++;
    if (n >= BUDGET) begin errors++; $display("FAIL mid_reach_wr_d1: not reached, required WR_D1 strobe"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, mst_lb_wr_en, mst_lb_rd_en, mst_lb_addr, mst_lb_wr_data, seq_busy, nack_err, cmd_done_cnt} !== '0) begin
      errors++; $display("FAIL mid_async_reset: got rdy=%b wr=%b addr=%h busy=%b done=%0d, required all 0", cmd_ready, mst_lb_wr_en, mst_lb_addr, seq_busy, cmd_done_cnt);
    end
    repeat (2) @(negedge clk);
    model_init();
    rst_n = 1'b1;
    @(negedge clk);
    wait_idle(ok);
    repeat (20) @(negedge clk);
    checks++;
    if (!ok || first_wr_diff() != -1 || seq_busy !== 1'b0 || cmd_done_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_restart: ok=%b writes=%0d busy=%b done=%0d, required ok=1 writes=2 busy=0 done=0", ok, wr_log.size(), seq_busy, cmd_done_cnt);
    end
  endtask

`ifdef I2C_CMD_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    int held, d;
    int idx = nxt;
    busy_tbl[idx] = 1000; nack_tbl[idx] = 0;
    push_cmd(16'h0F0F, held);
    model_cmd(16'h0F0F); nxt++;
    wait_idle(ok);
    checks++;
    if (!ok || rd_cnt[idx] != 4 || timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout: ok=%b reads=%0d tmo=%b, required ok=1 reads=4 tmo=1", ok, rd_cnt[idx], timeout_err);
    end
    checks++;
    if (cmd_done_cnt !== 16'(exp_done)) begin errors++; $display("FAIL timeout_done: got %0d required %0d", cmd_done_cnt, exp_done); end
    busy_tbl[nxt] = 0; nack_tbl[nxt] = 0;
    push_cmd(16'h00FF, held);
    model_cmd(16'h00FF); nxt++; exp_done++;
    wait_idle(ok);
    d = first_wr_diff();
    checks++;
    if (!ok || d != -1 || cmd_done_cnt !== 16'(exp_done)) begin
      errors++; $display("FAIL timeout_continue: diff=%0d done=%0d, required diff=-1 done=%0d", d, cmd_done_cnt, exp_done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_nack();
    test_reset_mid();
`ifdef I2C_CMD_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (proto_err != 0) begin errors++; $display("FAIL lb_protocol: got %0d violations required 0", proto_err); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
